// File: rtl/ysyx_22040895_seq_pkg.sv
// ysyx_22040895_seq_pkg: shared widths, reset PC, ebreak encoding and FSM states for the sequencer
package ysyx_22040895_seq_pkg;
  localparam int ADDR_W = 64;
  localparam int INST_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [INST_W-1:0] EBREAK = 32'h0010_0073;
  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_RSP, DECODE, EXEC, WB, TRAP, HALT
  } state_t;
endpackage

// File: rtl/ysyx_22040895_instret_cnt.sv
// ysyx_22040895_instret_cnt: 64-bit retired-instruction counter, cleared on reset, wraps at 2^64
module ysyx_22040895_instret_cnt import ysyx_22040895_seq_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (en) cnt <= cnt + 64'd1;
endmodule

// File: rtl/ysyx_22040895_seq.sv
// ysyx_22040895_seq: multi-cycle fetch/decode/execute/writeback sequencer; YSYX_22040895_EBREAK_HALT_EN enables ebreak halting
module ysyx_22040895_seq import ysyx_22040895_seq_pkg::*; #(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  input  logic              imem_rsp_err_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              dec_valid_o,
  output logic              exu_start_o,
  input  logic              exu_done_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              wb_en_o,
  output logic [ADDR_W-1:0] instret_o,
  output logic              trap_o,
  output logic              halt_o,
  output logic [2:0]        state_o
);
  state_t state;
  logic [ADDR_W-1:0] npc;
  assign imem_req_valid_o = state == FETCH;
  assign imem_req_addr_o  = pc_o;
  assign dec_valid_o      = state == DECODE || state == EXEC || state == WB;
  assign wb_en_o          = state == WB;
  assign trap_o           = state == TRAP;
  assign state_o          = state;
`ifdef YSYX_22040895_EBREAK_HALT_EN
  assign halt_o = state == HALT;
`else
  assign halt_o = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      pc_o        <= RESET_PC;
      inst_o      <= '0;
      npc         <= '0;
      exu_start_o <= 1'b0;
    end else begin
      exu_start_o <= 1'b0;
      case (state)
        IDLE:     if (run_i) state <= FETCH;
        FETCH:    if (imem_req_ready_i) state <= WAIT_RSP;
        WAIT_RSP: if (imem_rsp_valid_i) begin
          if (imem_rsp_err_i) state <= TRAP;
          else begin
            inst_o <= imem_rsp_data_i;
            state  <= DECODE;
          end
        end
        DECODE: begin
`ifdef YSYX_22040895_EBREAK_HALT_EN
          state       <= inst_o == EBREAK ? HALT : EXEC;
          exu_start_o <= inst_o != EBREAK;
`else
          state       <= EXEC;
          exu_start_o <= 1'b1;
`endif
        end
        // a misaligned taken target faults before anything is retired
        EXEC: if (exu_done_i) begin
          if (redirect_valid_i && redirect_pc_i[1:0] != 2'b00) state <= TRAP;
          else begin
            npc   <= redirect_valid_i ? redirect_pc_i : pc_o + 64'd4;
            state <= WB;
          end
        end
        WB: begin
          pc_o  <= npc;
          state <= FETCH;
        end
        TRAP: ;
        HALT: ;
      endcase
    end
  ysyx_22040895_instret_cnt u_instret_cnt (
    .clk (clk),
    .rst (rst),
    .en  (wb_en_o),
    .cnt (instret_o)
  );
endmodule

// File: tb/tb_ysyx_22040895_seq.sv
// tb_ysyx_22040895_seq: directed and randomized checks of the sequencer against a PC/retire model
module tb_ysyx_22040895_seq;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  logic clk = 1'b0, rst = 1'b1, run_i = 1'b0;
  logic imem_req_valid_o, imem_req_ready_i = 1'b0;
  logic [63:0] imem_req_addr_o;
  logic imem_rsp_valid_i = 1'b0, imem_rsp_err_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0, inst_o;
  logic [63:0] pc_o, instret_o, redirect_pc_i = '0;
  logic dec_valid_o, exu_start_o, exu_done_i = 1'b0, redirect_valid_i = 1'b0;
  logic wb_en_o, trap_o, halt_o;
  logic [2:0] state_o;
  int tests = 0, fails = 0;
  logic [63:0] mpc, mret;
  logic [31:0] minst;

  ysyx_22040895_seq dut (
    .clk(clk), .rst(rst), .run_i(run_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .imem_rsp_err_i(imem_rsp_err_i),
    .inst_o(inst_o), .pc_o(pc_o), .dec_valid_o(dec_valid_o), .exu_start_o(exu_start_o),
    .exu_done_i(exu_done_i), .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .wb_en_o(wb_en_o), .instret_o(instret_o), .trap_o(trap_o), .halt_o(halt_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_pc", pc_o, RPC);
    chk("rst_instret", instret_o, 64'd0);
    chk("rst_inst", {32'd0, inst_o}, 64'd0);
    chk("rst_outs", {58'd0, imem_req_valid_o, dec_valid_o, exu_start_o, wb_en_o, trap_o, halt_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    mpc = RPC;
    mret = '0;
    minst = '0;
  endtask

  task automatic start();
    run_i = 1'b1;
    step();
    run_i = 1'b0;
  endtask

  // drives one instruction through the handshake with the given wait counts and checks every cycle
  task automatic do_instr(input logic [31:0] inst, input int rw, input int sw, input int dw,
                          input logic redir, input logic [63:0] tgt, input logic err);
    for (int i = 0; i <= rw; i++) begin
      chk("fetch_valid", {63'd0, imem_req_valid_o}, 64'd1);
      chk("fetch_addr", imem_req_addr_o, mpc);
      imem_req_ready_i = (i == rw);
      step();
    end
    imem_req_ready_i = 1'b0;
    for (int i = 0; i <= sw; i++) begin
      chk("wait_no_req", {63'd0, imem_req_valid_o}, 64'd0);
      chk("wait_no_dec", {63'd0, dec_valid_o}, 64'd0);
      imem_rsp_valid_i = (i == sw);
      imem_rsp_data_i = inst;
      imem_rsp_err_i = err;
      step();
    end
    imem_rsp_valid_i = 1'b0;
    imem_rsp_err_i = 1'b0;
    if (err) begin
      for (int i = 0; i < 3; i++) begin
        chk("err_trap", {63'd0, trap_o}, 64'd1);
        chk("err_no_dec", {63'd0, dec_valid_o}, 64'd0);
        chk("err_no_req", {63'd0, imem_req_valid_o}, 64'd0);
        chk("err_inst", {32'd0, inst_o}, {32'd0, minst});
        step();
      end
      return;
    end
    minst = inst;
    chk("dec_valid", {63'd0, dec_valid_o}, 64'd1);
    chk("dec_inst", {32'd0, inst_o}, {32'd0, inst});
    chk("dec_pc", pc_o, mpc);
    chk("dec_no_start", {63'd0, exu_start_o}, 64'd0);
    step();
`ifdef YSYX_22040895_EBREAK_HALT_EN
    if (inst == EBRK) begin
      for (int i = 0; i < 3; i++) begin
        chk("halt_flag", {63'd0, halt_o}, 64'd1);
        chk("halt_no_start", {63'd0, exu_start_o}, 64'd0);
        chk("halt_no_req", {63'd0, imem_req_valid_o}, 64'd0);
        chk("halt_instret", instret_o, mret);
        step();
      end
      return;
    end
`endif
    for (int i = 0; i <= dw; i++) begin
      chk("exec_dec_valid", {63'd0, dec_valid_o}, 64'd1);
      chk("exec_start", {63'd0, exu_start_o}, {63'd0, i == 0});
      chk("exec_no_wb", {63'd0, wb_en_o}, 64'd0);
      exu_done_i = (i == dw);
      redirect_valid_i = redir;
      redirect_pc_i = tgt;
      step();
    end
    exu_done_i = 1'b0;
    redirect_valid_i = 1'b0;
    if (redir && tgt[1:0] != 2'b00) begin
      for (int i = 0; i < 3; i++) begin
        chk("mis_trap", {63'd0, trap_o}, 64'd1);
        chk("mis_no_req", {63'd0, imem_req_valid_o}, 64'd0);
        chk("mis_no_wb", {63'd0, wb_en_o}, 64'd0);
        chk("mis_instret", instret_o, mret);
        chk("mis_pc", pc_o, mpc);
        step();
      end
      return;
    end
    chk("wb_en", {63'd0, wb_en_o}, 64'd1);
    chk("wb_old_pc", pc_o, mpc);
    step();
    mpc = redir ? tgt : mpc + 64'd4;
    mret = mret + 64'd1;
    chk("wb_done_no_en", {63'd0, wb_en_o}, 64'd0);
    chk("next_pc", pc_o, mpc);
    chk("instret", instret_o, mret);
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step();
      chk("idle_no_req", {63'd0, imem_req_valid_o}, 64'd0);
    end
    start();
    do_instr(NOP, 0, 0, 0, 1'b0, '0, 1'b0);
    do_instr(NOP, 3, 0, 0, 1'b0, '0, 1'b0);
    do_instr(NOP, 0, 1, 2, 1'b1, 64'h0000_0000_8000_0100, 1'b0);
    for (int n = 0; n < 20; n++)
      do_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3) == 0, {$urandom, $urandom} & ~64'd3, 1'b0);
    do_instr(NOP, 0, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    do_instr(NOP, 1, 0, 0, 1'b0, '0, 1'b0);
    force dut.u_instret_cnt.cnt = '1;
    #1 release dut.u_instret_cnt.cnt;
    mret = '1;
    do_instr(NOP, 0, 0, 0, 1'b0, '0, 1'b0);
    do_instr(EBRK, 0, 0, 0, 1'b0, '0, 1'b0);
    do_reset();
    start();
    do_instr(NOP, 0, 0, 0, 1'b1, 64'h0000_0000_8000_0102, 1'b0);
    do_reset();
    start();
    do_instr(NOP, 0, 0, 0, 1'b0, '0, 1'b0);
    do_instr(NOP, 0, 2, 0, 1'b0, '0, 1'b1);
    do_reset();
    start();
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    #2 rst = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = 32'hDEAD_BEEF;
    #1;
    chk("abort_pc", pc_o, RPC);
    chk("abort_no_req", {63'd0, imem_req_valid_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("late_rsp_no_dec", {63'd0, dec_valid_o}, 64'd0);
      chk("late_rsp_inst", {32'd0, inst_o}, 64'd0);
      chk("late_rsp_idle", {63'd0, imem_req_valid_o}, 64'd0);
    end
    imem_rsp_valid_i = 1'b0;
    mpc = RPC;
    mret = '0;
    minst = '0;
    start();
    do_instr(NOP, 0, 0, 0, 1'b0, '0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ysyx_22040895_seq.md
YSYX_22040895_SEQ -- requirements
Module: ysyx_22040895_seq

Interface
REQ-001 SHALL have parameter: RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
REQ-002 SHALL have ports (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge.
  rst  in  1  reset, asynchronous, active-low.
  run_i  in  1  leave IDLE and begin sequencing.
  imem_req_valid_o  out  1  fetch request valid.
  imem_req_ready_i  in  1  memory accepts request.
  imem_req_addr_o  out  64  fetch address (= pc_o).
  imem_rsp_valid_i  in  1  fetch data valid.
  imem_rsp_data_i  in  32  fetched instruction.
  imem_rsp_err_i  in  1  fetch bus error, qualified by rsp_valid.
  inst_o  out  32  instruction register, feeds decoder.
  pc_o  out  64  current PC, feeds decoder.
  dec_valid_o  out  1  inst_o/pc_o valid for decode.
  exu_start_o  out  1  one-cycle execute start pulse.
  exu_done_i  in  1  execute complete.
  redirect_valid_i  in  1  branch/jal taken, qualified by exu_done_i.
  redirect_pc_i  in  64  taken target.
  wb_en_o  out  1  one-cycle register write-back enable.
  instret_o  out  64  retired-instruction counter.
  trap_o  out  1  sticky fault flag.
  halt_o  out  1  sticky halt flag (macro-dependent, REQ-020).
  state_o  out  3  current FSM state encoding, debug only.

Function
REQ-003 SHALL implement states IDLE, FETCH, WAIT_RSP, DECODE, EXEC, WB, TRAP, HALT.
REQ-004 IDLE: SHALL move to FETCH the cycle after run_i is sampled high; run_i ignored in all other states.
REQ-005 FETCH: SHALL hold imem_req_valid_o=1, addr=pc_o stable until imem_req_ready_i; on handshake go WAIT_RSP.
REQ-006 WAIT_RSP: SHALL wait for imem_rsp_valid_i; with err=0 latch data into inst_o, go DECODE; with err=1 go TRAP, inst_o unchanged.
REQ-007 imem_rsp_valid_i in any state except WAIT_RSP SHALL be ignored.
REQ-008 DECODE: SHALL last exactly one cycle with dec_valid_o=1; dec_valid_o=1 also in EXEC and WB, 0 elsewhere.
REQ-009 EXEC: exu_start_o SHALL pulse high only on the first EXEC cycle; stay until exu_done_i, then go WB (done on the first EXEC cycle is legal).
REQ-010 Next PC SHALL be captured when exu_done_i=1: redirect_valid_i ? redirect_pc_i : pc_o+4, addition modulo 2^64.
REQ-011 Redirect with redirect_pc_i[1:0]!=0 SHALL go TRAP instead of WB; pc_o unchanged, no retire.
REQ-012 WB: SHALL last one cycle with wb_en_o=1; pc_o updates to next PC and instret_o increments (wraps at 2^64) at end of WB; then FETCH.
REQ-013 Minimum instruction latency SHALL be 5 cycles (FETCH, WAIT_RSP, DECODE, EXEC, WB) with zero-wait memory and execute.
REQ-014 TRAP: SHALL set trap_o=1, drive all request/pulse outputs 0, and remain until reset.
REQ-015 Only one fetch SHALL be outstanding; no new request before response of the previous one.

Reset
REQ-016 On rst low, asynchronously: state=IDLE, pc_o=RESET_PC, inst_o=0, instret_o=0, trap_o=0, halt_o=0, all valid/pulse/enable outputs 0.
REQ-017 Reset mid-operation SHALL abort immediately, including a handshake or outstanding response; a response arriving after reset is dropped per REQ-007.
REQ-018 Leaving reset SHALL be synchronous to clk; the first clk edge after release sees state IDLE.

Configuration
REQ-019 Macro YSYX_22040895_EBREAK_HALT_EN SHALL control ebreak halting.
REQ-020 With macro: DECODE of inst 32'h0010_0073 SHALL go HALT (halt_o=1 sticky, no exu_start_o, no retire) until reset. Without macro: ebreak sequenced as an ordinary instruction, halt_o tied 0, HALT state absent.

Structure
REQ-021 State encodings, RESET_PC default, EBREAK encoding and width constants (64-bit address, 32-bit instruction) SHALL live in the shared define package.
REQ-022 Retire counter SHALL be a sub-module ysyx_22040895_instret_cnt (enable, clear-on-reset, 64-bit wrap).

Verification
REQ-023 Reset, run_i=1, ready/rsp zero-wait, inst 32'h0000_0013, done on first EXEC cycle -> req addr 8000_0000, wb_en_o in cycle 5, pc_o=8000_0004, instret_o=1.
REQ-024 imem_req_ready_i low 3 cycles -> addr and valid stable for 4 cycles, single handshake, latency 8 cycles.
REQ-025 Redirect_valid_i=1, redirect_pc_i=8000_0100 with exu_done_i -> next fetch addr 8000_0100; redirect_pc_i=8000_0102 -> trap_o=1, instret_o unchanged, no further requests.
REQ-026 imem_rsp_err_i=1 with rsp_valid -> TRAP, dec_valid_o never asserted; rst pulse low during WAIT_RSP -> IDLE, pc_o=8000_0000, late rsp_valid ignored.
REQ-027 Macro defined, fetch 32'h0010_0073 -> halt_o=1 after DECODE, exu_start_o never pulses; macro undefined -> normal retire, instret_o=1.
REQ-028 pc_o=FFFF_FFFF_FFFF_FFFC, no redirect -> next pc_o=0; instret_o preloaded via force to all-ones -> wraps to 0.
